// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory: DM has priority, IF is protected
// from starvation by a bounded loss counter. One access is outstanding at a time.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_data_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_valid_o,
    output logic [DATA_W-1:0] dm_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              stall_o
);

    localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm} state_e;

    state_e            state_q;
    logic [CntW-1:0]   starve_q;
    logic              if_gnt_q, if_valid_q, dm_gnt_q, dm_valid_q;
    logic [DATA_W-1:0] if_data_q, dm_rdata_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // A requester is ignored in its own completion cycle so a held req is not relaunched.
    logic if_elig, dm_elig;
    assign if_elig = if_req_i & ~if_valid_q;
    assign dm_elig = dm_req_i & ~dm_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            if_data_q   <= '0;
            dm_gnt_q    <= 1'b0;
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_gnt_q   <= 1'b0;
            dm_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_elig && (!dm_elig || starve_q == StarveMax)) begin
                        state_q     <= StBusyIf;
                        starve_q    <= '0;
                        if_gnt_q    <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                    end else if (dm_elig) begin
                        state_q     <= StBusyDm;
                        dm_gnt_q    <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                        // Reaching here with IF eligible implies starve_q is below the limit.
                        if (if_elig) begin
                            starve_q <= starve_q + 1'b1;
                        end
                    end
                end
                StBusyIf: begin
                    if (mem_ack_i) begin
                        state_q    <= StIdle;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        if_valid_q <= 1'b1;
                        if_data_q  <= mem_rdata_i;
                    end
                end
                StBusyDm: begin
                    if (mem_ack_i) begin
                        state_q    <= StIdle;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        dm_valid_q <= 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_q <= mem_rdata_i;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign if_gnt_o    = if_gnt_q;
    assign if_valid_o  = if_valid_q;
    assign if_data_o   = if_data_q;
    assign dm_gnt_o    = dm_gnt_q;
    assign dm_valid_o  = dm_valid_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    assign stall_o = (if_req_i & ~if_valid_q) | (dm_req_i & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural memory, per-port completion scoreboards
// and cycle-exact checks of grant/valid/stall timing.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i, dm_req_i, dm_we_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
    logic        if_gnt_o, if_valid_o, dm_gnt_o, dm_valid_o;
    logic [31:0] if_data_o, dm_rdata_o;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        stall_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_if[$];
    logic [31:0] q_dm[$];
    bit [31:0]   mem[bit [31:0]];
    int          ack_lat;
    bit          ack_force;
    int          wait_cnt;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (2)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_valid_o  (if_valid_o),
        .if_data_o   (if_data_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_gnt_o    (dm_gnt_o),
        .dm_valid_o  (dm_valid_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    // Memory: acks after ack_lat extra busy cycles, or every cycle when ack_force is set.
    always @(negedge clk) begin
        if (mem_req_o) begin
            mem_ack_i = ack_force || (wait_cnt == ack_lat);
            wait_cnt++;
        end else begin
            mem_ack_i = ack_force;
            wait_cnt  = 0;
        end
        mem_rdata_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
        if (mem_ack_i && mem_req_o && mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
        end
    end

    always @(negedge clk) begin
        if (if_valid_o) begin
            if (q_if.size() == 0) chk("if_unexpected_valid", 64'(if_valid_o), 64'd0);
            else chk("if_data", 64'(if_data_o), 64'(q_if.pop_front()));
        end
        if (dm_valid_o) begin
            if (q_dm.size() == 0) chk("dm_unexpected_valid", 64'(dm_valid_o), 64'd0);
            else chk("dm_rdata", 64'(dm_rdata_o), 64'(q_dm.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_if, dm_done, if_seen;
        rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        ack_lat = 1; ack_force = 1'b0; wait_cnt = 0;
        mem[32'h10] = 32'hDEAD_BEEF;

        // Reset state
        repeat (3) step();
        nedge();
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_gnts", 64'({if_gnt_o, dm_gnt_o}), 64'd0);
        chk("rst_valids", 64'({if_valid_o, dm_valid_o}), 64'd0);
        chk("rst_data", {if_data_o, dm_rdata_o}, 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        step(); rst_i = 1'b0;
        step();

        // IF read, ack one cycle after launch
        step(); if_req_i = 1'b1; if_addr_i = 32'h10; q_if.push_back(32'hDEAD_BEEF);
        nedge();
        chk("t1_c0_stall", 64'(stall_o), 64'd1);
        chk("t1_c0_mem_req", 64'(mem_req_o), 64'd0);
        step(); nedge();
        chk("t1_c1_if_gnt", 64'(if_gnt_o), 64'd1);
        chk("t1_c1_mem_req", 64'(mem_req_o), 64'd1);
        chk("t1_c1_mem_addr", 64'(mem_addr_o), 64'h10);
        chk("t1_c1_mem_we", 64'(mem_we_o), 64'd0);
        step(); nedge();
        chk("t1_c2_if_gnt", 64'(if_gnt_o), 64'd0);
        chk("t1_c2_mem_req", 64'(mem_req_o), 64'd1);
        chk("t1_c2_stall", 64'(stall_o), 64'd1);
        step(); nedge();
        chk("t1_c3_if_valid", 64'(if_valid_o), 64'd1);
        chk("t1_c3_mem_req", 64'(mem_req_o), 64'd0);
        chk("t1_c3_stall", 64'(stall_o), 64'd0);
        step(); if_req_i = 1'b0; nedge();
        chk("t1_c4_no_relaunch", 64'(mem_req_o), 64'd0);

        // DM read to give dm_rdata_o a known value, zero-wait ack
        ack_lat = 0;
        step(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h10;
        q_dm.push_back(32'hDEAD_BEEF);
        step(); nedge();
        chk("t2r_dm_gnt", 64'(dm_gnt_o), 64'd1);
        step(); nedge();
        chk("t2r_dm_valid", 64'(dm_valid_o), 64'd1);
        step(); dm_req_i = 1'b0;

        // DM write; dm_rdata_o must hold the earlier read value
        ack_lat = 1;
        step(); dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'h5A5A_5A5A;
        q_dm.push_back(32'hDEAD_BEEF);
        step(); nedge();
        chk("t2_dm_gnt", 64'(dm_gnt_o), 64'd1);
        chk("t2_mem_we", 64'(mem_we_o), 64'd1);
        chk("t2_mem_addr", 64'(mem_addr_o), 64'h20);
        chk("t2_mem_wdata", 64'(mem_wdata_o), 64'h5A5A_5A5A);
        step(); nedge();
        chk("t2_mem_req_held", 64'(mem_req_o), 64'd1);
        step(); nedge();
        chk("t2_dm_valid", 64'(dm_valid_o), 64'd1);
        chk("t2_mem_we_drop", 64'(mem_we_o), 64'd0);
        step(); dm_req_i = 1'b0; dm_we_i = 1'b0;
        step();

        // Contention: DM first, IF in DM's completion cycle
        ack_lat = 0;
        step();
        if_req_i = 1'b1; if_addr_i = 32'h20; q_if.push_back(32'h5A5A_5A5A);
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h10; q_dm.push_back(32'hDEAD_BEEF);
        step(); nedge();
        chk("t3_dm_gnt", 64'({if_gnt_o, dm_gnt_o}), 64'b01);
        chk("t3_dm_addr", 64'(mem_addr_o), 64'h10);
        step(); nedge();
        chk("t3_dm_valid", 64'(dm_valid_o), 64'd1);
        chk("t3_gap_mem_req", 64'(mem_req_o), 64'd0);
        chk("t3_stall_if_waiting", 64'(stall_o), 64'd1);
        step(); dm_req_i = 1'b0; nedge();
        chk("t3_if_gnt", 64'({if_gnt_o, dm_gnt_o}), 64'b10);
        chk("t3_if_addr", 64'(mem_addr_o), 64'h20);
        step(); nedge();
        chk("t3_if_valid", 64'(if_valid_o), 64'd1);
        step(); if_req_i = 1'b0;
        step();

        // Starvation: IF withdraws after each loss; losses 1,2 -> DM, 3rd contest -> IF,
        // 4th -> DM again, showing the counter cleared.
        for (int r = 0; r < 4; r++) begin
            exp_if  = (r == 2);
            dm_done = 1'b0;
            if_seen = 1'b0;
            step();
            if_req_i = 1'b1; if_addr_i = 32'h10;
            dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20;
            q_dm.push_back(32'h5A5A_5A5A);
            if (exp_if) q_if.push_back(32'hDEAD_BEEF);
            step();
            if (!exp_if) if_req_i = 1'b0;
            nedge();
            chk($sformatf("t4_r%0d_gnt", r), 64'({if_gnt_o, dm_gnt_o}),
                exp_if ? 64'b10 : 64'b01);
            for (int k = 0; k < 10 && !dm_done; k++) begin
                step();
                if (if_seen) if_req_i = 1'b0;
                nedge();
                if (if_valid_o) if_seen = 1'b1;
                if (dm_valid_o) dm_done = 1'b1;
            end
            chk($sformatf("t4_r%0d_dm_done", r), 64'(dm_done), 64'd1);
            step(); if_req_i = 1'b0; dm_req_i = 1'b0;
        end

        // Reset in the second busy cycle of a DM access, late ack must be ignored
        ack_lat = 100;
        step(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h10;
        step(); nedge();
        chk("t5_dm_gnt", 64'(dm_gnt_o), 64'd1);
        step(); rst_i = 1'b1; nedge();
        chk("t5_busy_mem_req", 64'(mem_req_o), 64'd1);
        step(); rst_i = 1'b0; ack_force = 1'b1; dm_req_i = 1'b0; nedge();
        chk("t5_rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("t5_rst_mem_addr", 64'(mem_addr_o), 64'd0);
        chk("t5_rst_data", {if_data_o, dm_rdata_o}, 64'd0);
        chk("t5_rst_gnt_valid", 64'({if_gnt_o, dm_gnt_o, if_valid_o, dm_valid_o}), 64'd0);
        step(); ack_force = 1'b0; nedge();
        chk("t5_no_late_valid", 64'(dm_valid_o), 64'd0);
        ack_lat = 1;
        step(); if_req_i = 1'b1; if_addr_i = 32'h20; q_if.push_back(32'h5A5A_5A5A);
        step(); nedge();
        chk("t5_if_gnt", 64'(if_gnt_o), 64'd1);
        step(); step(); nedge();
        chk("t5_if_valid", 64'(if_valid_o), 64'd1);
        step(); if_req_i = 1'b0;
        step();

        // Ack tied high, both held: DM, IF, DM, IF with a completion every 2 cycles
        ack_force = 1'b1;
        step();
        if_req_i = 1'b1; if_addr_i = 32'h10;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20;
        repeat (2) q_dm.push_back(32'h5A5A_5A5A);
        repeat (2) q_if.push_back(32'hDEAD_BEEF);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 8) dm_req_i = 1'b0;
            nedge();
            chk($sformatf("t6_c%0d_pulses", c),
                64'({dm_gnt_o, if_gnt_o, dm_valid_o, if_valid_o}),
                64'({c % 4 == 1, c % 4 == 3, c % 4 == 2, c % 4 == 0}));
        end
        step(); if_req_i = 1'b0; ack_force = 1'b0;
        step(); nedge();
        chk("t6_idle_mem_req", 64'(mem_req_o), 64'd0);
        chk("end_queues_empty", 64'(q_if.size() + q_dm.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
